uctl_mem_ring_ctrl: RTL and testbench

Ring-buffer controller that sits directly upstream of the single-port endpoint packet memory and is its only master. It accepts a byte stream from the protocol engine on a write port and returns the stored bytes in order on a read port toward the system/DMA side. It arbitrates both streams onto the memory's one port (`mem_ce`, `rw_en`, `mem_addr`, data). It also absorbs the memory's one-cycle read latency with a 2-entry output queue, so the read port runs at full rate.

---
 rtl/uctl_mem_ring_ctrl.sv | 126 ++++++++++++
 tb/tb_uctl_mem_ring_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uctl_mem_ring_ctrl.sv
// rtl/uctl_mem_ring_ctrl.sv - ring-buffer controller arbitrating a byte write stream and an in-order read stream onto one single-port memory
// The read side hides the memory's one-cycle read latency behind a 2-entry output queue.
module uctl_mem_ring_ctrl #(
  parameter int MEM_ADDR_SIZE = 15,
  parameter int MEM_DATA_SIZE = 8
) (
  input  logic                     coreClk,
  input  logic                     coreRst_n,
  input  logic                     sw_rst,
  input  logic                     wr_valid,
  input  logic [MEM_DATA_SIZE-1:0] wr_data,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [MEM_DATA_SIZE-1:0] rd_data,
  input  logic                     rd_ready,
  output logic                     mem_ce,
  output logic                     mem_rw_en,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [MEM_DATA_SIZE-1:0] mem_wdata,
  input  logic [MEM_DATA_SIZE-1:0] mem_rdata,
  output logic [MEM_ADDR_SIZE:0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam logic [MEM_ADDR_SIZE:0] DEPTH = {1'b1, {MEM_ADDR_SIZE{1'b0}}};

  typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_e;

  logic [MEM_ADDR_SIZE-1:0] wptr, rptr, addr_q;
  logic [MEM_DATA_SIZE-1:0] wdata_q, q0, q1;
  logic [MEM_ADDR_SIZE:0]   level_q;
  logic [1:0]               q_cnt;
  logic                     inflight;
  grant_e                   last_grant;

  logic       run, pop, rd_req, wr_req, wr_gnt, rd_gnt;
  logic [2:0] occ;

  // Everything that touches the memory or the streams is frozen in reset and during a flush.
  assign run      = coreRst_n && !sw_rst;
  assign full     = (level_q == DEPTH);
  assign level    = level_q;
  assign empty    = (level_q == '0) && (q_cnt == 2'd0) && !inflight;
  assign rd_valid = run && (q_cnt != 2'd0);
  assign rd_data  = q0;
  assign pop      = rd_valid && rd_ready;

  // Queue occupancy counting the byte in flight; pop implies q_cnt >= 1 so no underflow.
  assign occ    = {1'b0, q_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_req = run && (level_q != '0) && (occ < 3'd2);
  assign wr_req = run && wr_valid && !full;

  assign wr_ready = run && !full && (!rd_req || last_grant == GNT_RD);
  assign wr_gnt   = wr_req && (!rd_req || last_grant == GNT_RD);
  assign rd_gnt   = rd_req && (!wr_req || last_grant == GNT_WR);

  assign mem_ce    = wr_gnt || rd_gnt;
  assign mem_rw_en = rd_gnt;
  assign mem_addr  = wr_gnt ? wptr : (rd_gnt ? rptr : addr_q);
  assign mem_wdata = wr_gnt ? wr_data : wdata_q;

  always_ff @(posedge coreClk or negedge coreRst_n) begin
    if (!coreRst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      level_q    <= '0;
      q0         <= '0;
      q1         <= '0;
      q_cnt      <= 2'd0;
      inflight   <= 1'b0;
      last_grant <= GNT_WR;
    end else if (sw_rst) begin
      // Address/data hold registers are left alone so the memory bus does not toggle.
      wptr       <= '0;
      rptr       <= '0;
      level_q    <= '0;
      q0         <= '0;
      q1         <= '0;
      q_cnt      <= 2'd0;
      inflight   <= 1'b0;
      last_grant <= GNT_WR;
    end else begin
      inflight <= rd_gnt;
      if (mem_ce) addr_q <= mem_addr;
      if (wr_gnt) begin
        wdata_q    <= wr_data;
        wptr       <= wptr + 1'b1;
        last_grant <= GNT_WR;
      end else if (rd_gnt) begin
        rptr       <= rptr + 1'b1;
        last_grant <= GNT_RD;
      end

      case ({wr_gnt, rd_gnt})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase

      case ({inflight, pop})
        2'b10: begin
          if (q_cnt == 2'd0) q0 <= mem_rdata;
          else               q1 <= mem_rdata;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          q_cnt <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q0 <= mem_rdata;
          end else begin
            q0 <= q1;
            q1 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uctl_mem_ring_ctrl.sv
// tb/tb_uctl_mem_ring_ctrl.sv - scoreboard bench for uctl_mem_ring_ctrl with an 8-entry ring
module tb_uctl_mem_ring_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH_TB = 8;

  logic          coreClk = 1'b0;
  logic          coreRst_n, sw_rst, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ce, mem_rw_en, full, empty;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   level;

  logic [DW-1:0] mem [0:DEPTH_TB-1];
  logic [DW-1:0] vec [0:127];
  logic [DW-1:0] exp_q [$];
  int errors = 0, checks = 0, cyc = 0;
  int exp_wa = 0, exp_ra = 0, first_rv = -1, t_acc = 0;

  uctl_mem_ring_ctrl #(.MEM_ADDR_SIZE(AW), .MEM_DATA_SIZE(DW)) dut (
    .coreClk(coreClk), .coreRst_n(coreRst_n), .sw_rst(sw_rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .mem_ce(mem_ce), .mem_rw_en(mem_rw_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .level(level), .full(full), .empty(empty)
  );

  always #5 coreClk = ~coreClk;
  always @(posedge coreClk) cyc = cyc + 1;

  // Single-port memory with registered read data.
  always @(posedge coreClk) begin
    if (mem_ce) begin
      if (mem_rw_en) mem_rdata <= mem[mem_addr];
      else           mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-address and output-stream monitor.
  initial begin
    forever begin
      @(negedge coreClk);
      if (mem_ce && mem_rw_en) begin
        chk("rd_addr", 32'(mem_addr), 32'(exp_ra));
        exp_ra = (exp_ra + 1) % DEPTH_TB;
      end
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got 0x%0h expected none", rd_data);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send(input int n, input bit rnd, input bit chk_alt);
    int i = 0;
    int k = 0;
    while (i < n && k < 2000) begin
      @(posedge coreClk); #1;
      wr_valid = 1'b1;
      wr_data  = vec[i];
      if (rnd) rd_ready = 1'($urandom_range(0, 1));
      @(negedge coreClk);
      if (chk_alt) begin
        chk("alt_ce", 32'(mem_ce), 32'd1);
        chk("alt_rw", 32'(mem_rw_en), 32'(k % 2));
        chk("alt_wr_ready", 32'(wr_ready), 32'(k % 2 == 0));
      end
      if (wr_ready) begin
        chk("wr_access", {29'd0, mem_ce, mem_rw_en, 1'b0}, {29'd0, 3'b100});
        chk("wr_addr", 32'(mem_addr), 32'(exp_wa));
        chk("wr_wdata", 32'(mem_wdata), 32'(vec[i]));
        if (i == 0) t_acc = cyc;
        exp_q.push_back(vec[i]);
        exp_wa = (exp_wa + 1) % DEPTH_TB;
        i++;
      end
      k++;
    end
    chk("send_done", 32'(i), 32'(n));
    @(posedge coreClk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    @(posedge coreClk); #1;
    rd_ready = 1'b1;
    while (k < 300 && !(exp_q.size() == 0 && empty)) begin
      @(negedge coreClk); #1;
      k++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    coreRst_n = 1'b0; sw_rst = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #12;
    chk("rst_mem_ce", 32'(mem_ce), 32'd0);
    chk("rst_mem_rw_en", 32'(mem_rw_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    @(posedge coreClk); #1;
    coreRst_n = 1'b1;
    @(negedge coreClk);
    chk("rel_wr_ready", 32'(wr_ready), 32'd1);

    // Ordering, latency and write/read alternation under contention.
    for (int i = 0; i < 4; i++) vec[i] = 8'h11 + 8'(i);
    rd_ready = 1'b1;
    first_rv = -1;
    send(4, 1'b0, 1'b1);
    drain();
    chk("latency", 32'(first_rv - t_acc), 32'd3);

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 10; i++) vec[i] = 8'h11 + 8'(i);
    rd_ready = 1'b0;
    send(10, 1'b0, 1'b0);
    repeat (2) @(negedge coreClk);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    chk("fill_rd_valid", 32'(rd_valid), 32'd1);
    chk("fill_rd_data", 32'(rd_data), 32'h11);
    @(posedge coreClk); #1;
    rd_ready = 1'b1;
    @(negedge coreClk);
    chk("fill_rd_issue", {30'd0, mem_ce, mem_rw_en}, 32'd3);
    @(negedge coreClk);
    chk("fill_full_clear", 32'(full), 32'd0);
    drain();

    // Wrap-around streaming.
    for (int i = 0; i < 20; i++) vec[i] = 8'(i);
    send(20, 1'b0, 1'b0);
    drain();

    // Random back-pressure.
    for (int i = 0; i < 100; i++) vec[i] = 8'((i * 37 + 5) & 255);
    send(100, 1'b1, 1'b0);
    drain();

    // Flush with a read in flight.
    vec[0] = 8'hA5;
    send(1, 1'b0, 1'b0);
    @(negedge coreClk);
    chk("fl_rd_issue", {30'd0, mem_ce, mem_rw_en}, 32'd3);
    @(posedge coreClk); #1;
    sw_rst = 1'b1;
    @(negedge coreClk);
    chk("fl_mem_ce", 32'(mem_ce), 32'd0);
    chk("fl_wr_ready", 32'(wr_ready), 32'd0);
    chk("fl_rd_valid", 32'(rd_valid), 32'd0);
    exp_q.delete();
    exp_wa = 0;
    exp_ra = 0;
    @(posedge coreClk); #1;
    sw_rst = 1'b0;
    @(negedge coreClk);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_rd_valid_after", 32'(rd_valid), 32'd0);
    repeat (4) @(negedge coreClk);
    vec[0] = 8'hC0; vec[1] = 8'hC1;
    send(2, 1'b0, 1'b0);
    drain();

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) vec[i] = 8'h50 + 8'(i);
    rd_ready = 1'b0;
    send(5, 1'b0, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    @(posedge coreClk); #3;
    coreRst_n = 1'b0;
    #1;
    chk("ar_mem_ce", 32'(mem_ce), 32'd0);
    chk("ar_mem_addr", 32'(mem_addr), 32'd0);
    chk("ar_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("ar_rd_valid", 32'(rd_valid), 32'd0);
    chk("ar_rd_data", 32'(rd_data), 32'd0);
    chk("ar_level", 32'(level), 32'd0);
    chk("ar_full", 32'(full), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    wr_valid = 1'b0;
    exp_q.delete();
    exp_wa = 0;
    exp_ra = 0;
    @(posedge coreClk); #1;
    coreRst_n = 1'b1;
    @(negedge coreClk);
    chk("ar_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 3; i++) vec[i] = 8'h60 + 8'(i);
    rd_ready = 1'b1;
    send(3, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
